// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port, registered-read data memory between
// two Avalon-style masters (M0 = CPU data port, M1 = bench loader/checker).
// Arbitration is round-robin. A byte-enabled write becomes a
// read-modify-write, because the memory only stores full words.
// Optional feature macro: DMEM_ARB_RANGE_CHECK_EN. When it is defined, every
// access is checked against the BASE/SIZE window and for word alignment, and
// the sticky err output is set on a violation. When it is not defined, err is
// tied low.
//
// Handshake: a master holds read/write and its address, data and byteenable
// stable while its waitrequest is high. The transfer completes in the single
// cycle where that master's waitrequest is low. For a read, readdatavalid and
// readdata are valid in that same cycle.
module dmem_arbiter #(
  parameter logic [31:0] BASE = 32'h1000_0000,
  parameter int unsigned SIZE = 512
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] m0_address,
  input  logic [31:0] m1_address,
  input  logic        m0_read,
  input  logic        m1_read,
  input  logic        m0_write,
  input  logic        m1_write,
  input  logic [31:0] m0_writedata,
  input  logic [31:0] m1_writedata,
  input  logic [3:0]  m0_byteenable,
  input  logic [3:0]  m1_byteenable,
  output logic        m0_waitrequest,
  output logic        m1_waitrequest,
  output logic [31:0] m0_readdata,
  output logic [31:0] m1_readdata,
  output logic        m0_readdatavalid,
  output logic        m1_readdatavalid,
  output logic [31:0] mem_address,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} state_t;

  state_t      state, state_nxt;
  logic        gnt;          // master that owns the current transfer (1 = M1)
  logic        last_grant;   // master granted most recently
  logic        is_wr;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;

  logic        req0, req1, any_req, sel, s_wr, s_err;
  logic [31:0] s_addr, s_wdata, merged;
  logic [3:0]  s_be;

  // The window must describe whole words.
  if (BASE[1:0] != 2'b00 || SIZE < 4 || (SIZE % 4) != 0) begin : g_cfg_check
    $error("dmem_arbiter: BASE and SIZE must be word aligned");
  end

  // Pick the requester: on a tie the master not granted last wins.
  always_comb begin
    req0    = m0_read | m0_write;
    req1    = m1_read | m1_write;
    any_req = req0 | req1;
    sel     = (req0 && req1) ? ~last_grant : req1;
    s_addr  = sel ? m1_address    : m0_address;
    s_wdata = sel ? m1_writedata  : m0_writedata;
    s_be    = sel ? m1_byteenable : m0_byteenable;
    s_wr    = sel ? m1_write      : m0_write;   // read+write together counts as a write
  end

`ifdef DMEM_ARB_RANGE_CHECK_EN
  localparam logic [31:0] LAST_WORD = BASE + 32'(SIZE) - 32'd4;

  // An access is illegal outside the window or when not word aligned.
  always_comb begin
    s_err = (s_addr < BASE) || (s_addr > LAST_WORD) || (s_addr[1:0] != 2'b00);
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else if (state == IDLE && any_req && s_err) err <= 1'b1;
  end
`else
  assign s_err = 1'b0;
  assign err   = 1'b0;
`endif

  // Byte-lane merge of new write data over the word read back from memory.
  always_comb begin
    merged = mem_readdata;
    for (int k = 0; k < 4; k++) begin
      if (be_q[k]) merged[8*k +: 8] = wdata_q[8*k +: 8];
    end
  end

  // Next-state sequencing of a single transfer.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          if (s_err)               state_nxt = DONE;
          else if (!s_wr)          state_nxt = RD;
          else if (s_be == 4'h0)   state_nxt = DONE;
          else if (s_be == 4'hF)   state_nxt = WR;
          else                     state_nxt = RD;
        end
      end
      RD:      state_nxt = CAP;
      CAP:     state_nxt = is_wr ? WR : DONE;
      WR:      state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Registered datapath: request capture, memory strobes and read returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt              <= 1'b0;
      last_grant       <= 1'b1;
      is_wr            <= 1'b0;
      wdata_q          <= '0;
      be_q             <= '0;
      mem_address      <= '0;
      mem_write        <= 1'b0;
      mem_writedata    <= '0;
      m0_readdata      <= '0;
      m1_readdata      <= '0;
      m0_readdatavalid <= 1'b0;
      m1_readdatavalid <= 1'b0;
    end else begin
      mem_write        <= 1'b0;
      m0_readdatavalid <= 1'b0;
      m1_readdatavalid <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt        <= sel;
            last_grant <= sel;
            is_wr      <= s_wr;
            wdata_q    <= s_wdata;
            be_q       <= s_be;
            if (state_nxt == RD || state_nxt == WR) mem_address <= s_addr;
            if (state_nxt == WR) begin
              mem_write     <= 1'b1;
              mem_writedata <= s_wdata;
            end
            // A rejected read still completes, returning zero.
            if (s_err && !s_wr) begin
              if (sel) begin
                m1_readdata      <= '0;
                m1_readdatavalid <= 1'b1;
              end else begin
                m0_readdata      <= '0;
                m0_readdatavalid <= 1'b1;
              end
            end
          end
        end
        CAP: begin
          if (is_wr) begin
            mem_write     <= 1'b1;
            mem_writedata <= merged;
          end else if (gnt) begin
            m1_readdata      <= mem_readdata;
            m1_readdatavalid <= 1'b1;
          end else begin
            m0_readdata      <= mem_readdata;
            m0_readdatavalid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Only the owner of a finishing transfer is released.
  assign m0_waitrequest = !(state == DONE && !gnt);
  assign m1_waitrequest = !(state == DONE &&  gnt);

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer in front of the single-port testbench data memory. It shares the memory between the CPU data port (M0) and a bench loader/checker port (M1) using round-robin grant and Avalon-style waitrequest/readdatavalid handshakes. Byte-enabled writes are turned into read-modify-write sequences, because the memory only performs full-word writes and has a registered (1-cycle) read. Optionally, it range-checks and alignment-checks every access.

## Interface
Parameters:
- BASE, 32'h10000000, first byte address of memory window
- SIZE, 512, window size in bytes

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- m0_address, m1_address  in  32  byte address, word-aligned
- m0_read, m1_read  in  1  read request
- m0_write, m1_write  in  1  write request
- m0_writedata, m1_writedata  in  32  write data, lane k = byte at address+k
- m0_byteenable, m1_byteenable  in  4  write byte lanes
- m0_waitrequest, m1_waitrequest  out  1  high = hold request stable
- m0_readdata, m1_readdata  out  32  read data
- m0_readdatavalid, m1_readdatavalid  out  1  read data valid, 1 cycle
- mem_address  out  32  memory address
- mem_write  out  1  memory full-word write strobe
- mem_writedata  out  32  memory write data
- mem_readdata  in  32  memory data for address of previous cycle
- err  out  1  sticky access error

## Operation
- States: IDLE, RD, CAP, WR, DONE. All outputs are registered except mX_waitrequest.
- IDLE:
  - If any master has read or write asserted, grant one of them and capture its address, data, byteenable and op.
  - Round-robin: if both request, the master not granted last wins. last_grant resets to M1, so M0 wins the first tie.
  - If one master asserts read and write together, it is treated as a write.
- Read: IDLE→RD (mem_address driven) →CAP (mem_readdata latched) →DONE.
- Write with byteenable 4'hF: IDLE→WR→DONE. During WR, mem_write=1.
- Partial write (byteenable neither 0 nor F): IDLE→RD→CAP→WR→DONE.
  - Merge per lane: byteenable[k] selects writedata lane k, otherwise the captured mem_readdata lane k.
- byteenable 4'h0 write: IDLE→DONE, with no memory access.
- DONE:
  - The granted master's waitrequest is low.
  - For reads, its readdatavalid=1 and readdata=captured word.
  - Next state is IDLE. A request still held in DONE is a new request and is arbitrated in IDLE.
- mX_waitrequest is high in every cycle except DONE for the granted master, including idle cycles.
- A master is never granted twice in succession while the other is requesting.

## Timing
- Reset (async, immediate):
  - state=IDLE, mem_write=0, mem_address=0, mem_writedata=0.
  - mX_readdata=0, mX_readdatavalid=0, mX_waitrequest=1, err=0, last_grant=M1.
- Reset mid-transfer drops the transfer. mem_write falls without waiting for clk.
- Latency, counted from the first request cycle in IDLE (cycle 0) to waitrequest low:
  - read: 3 cycles
  - full write: 2 cycles
  - partial write: 4 cycles
  - byteenable 0: 1 cycle
- readdatavalid is high exactly one cycle, coincident with waitrequest low.
- mem_write is high for exactly one cycle per write transfer. mem_address is stable from RD/WR entry to DONE.
- Address arithmetic is 32-bit unsigned. The window end is BASE+SIZE-1, with no wrap.

## Configuration
- DMEM_ARB_RANGE_CHECK_EN defined:
  - In IDLE, an access is an error if address < BASE, address > BASE+SIZE-4, or address[1:0]≠0.
  - An error access goes IDLE→DONE with no memory cycle. Reads return 32'h0 with readdatavalid=1.
  - err is set and stays set until reset.
- Not defined: all accesses are forwarded unchecked and err is tied 0.

## Test plan
- Reset and idle:
  - Stimulus: rst_n low, then high, with no requests.
  - Required: both waitrequest=1, err=0, mem_write never asserted.
- M0 full write then read back:
  - Stimulus: M0 writes 32'hDEADBEEF, byteenable F, to 32'h10000010, then reads the same address.
  - Required: waitrequest low at cycle 2 of the write; for the read, waitrequest low at cycle 3 with readdatavalid=1 and readdata=32'hDEADBEEF.
- Partial write:
  - Stimulus: word 32'h11223344 preloaded at 32'h10000020; M1 writes 32'h000000AA with byteenable 4'b0001.
  - Required: waitrequest low at cycle 4; a subsequent read returns 32'h112233AA.
- Simultaneous requests:
  - Stimulus: M0 and M1 both request reads continuously from reset.
  - Required: grants alternate M0, M1, M0, M1; neither master waits more than one other transfer.
- Reset mid-op:
  - Stimulus: rst_n low during RD of a partial write.
  - Required: mem_write never pulses and the memory word is unchanged.
- Range check (macro defined):
  - Stimulus: M0 reads 32'h10000200, then reads 32'h10000002.
  - Required: each completes at cycle 1 with readdata=0; err=1 and stays 1; no memory access occurs.
